// File: rtl/fetch_line_aligner_if.sv
// Handshake bundle between the fetch-line aligner, the I-cache line-return
// port and the instruction buffer write port.
interface fetch_line_aligner_if #(
    parameter int ADDR_WIDTH = 48,
    parameter int LINE_BYTES = 64
);
    logic                    req_valid;
    logic                    req_ready;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic                    line_valid;
    logic                    line_ready;
    logic [ADDR_WIDTH-1:0]   line_addr;
    logic [LINE_BYTES*8-1:0] line_data;
    logic                    line_err;
    logic                    out_valid;
    logic                    out_ready;
    logic [31:0]             out_data;
    logic                    out_last;
    logic                    out_err;

    modport master (
        output req_valid, req_addr, line_valid, line_addr, line_data, line_err, out_ready,
        input  req_ready, line_ready, out_valid, out_data, out_last, out_err
    );

    modport slave (
        input  req_valid, req_addr, line_valid, line_addr, line_data, line_err, out_ready,
        output req_ready, line_ready, out_valid, out_data, out_last, out_err
    );
endinterface

// File: rtl/fetch_line_aligner.sv
// Splits one fetch packet, possibly spanning two cache lines, into a stream of
// 32-bit instruction words in address order.
module fetch_line_aligner #(
    parameter int ADDR_WIDTH  = 48,
    parameter int LINE_BYTES  = 64,
    parameter int FETCH_BYTES = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    fetch_line_aligner_if.slave  bus,
    output logic                 stale_drop,
    output logic                 busy
);
    localparam int NW   = FETCH_BYTES / 4;
    localparam int LW   = LINE_BYTES / 4;
    localparam int LB   = $clog2(LINE_BYTES);
    localparam int WI_W = LB - 2;
    localparam int K_W  = $clog2(NW) + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_L0 = 3'd1,
        DRAIN_0 = 3'd2,
        WAIT_L1 = 3'd3,
        DRAIN_1 = 3'd4
    } state_t;

    state_t                  state_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [LINE_BYTES*8-1:0] line_buf_r;
    logic                    line_err_r;
    logic [WI_W-1:0]         widx_r;
    logic [K_W-1:0]          k_r;
    logic                    out_valid_r;
    logic [31:0]             out_data_r;
    logic                    out_last_r;
    logic                    out_err_r;
    logic                    stale_drop_r;
    logic                    req_ready_r;
    logic                    line_ready_r;
    logic                    busy_r;

    logic [ADDR_WIDTH-1:0]   base0_s;
    logic [ADDR_WIDTH-1:0]   base1_s;
    logic [ADDR_WIDTH-1:0]   want_base_s;
    logic                    line_fire_s;
    logic                    line_hit_s;
    logic                    out_fire_s;
    logic                    line_end_s;
    logic [WI_W-1:0]         first_widx_s;
    logic [WI_W-1:0]         next_widx_s;
    logic [K_W-1:0]          k_load_s;
    logic [K_W-1:0]          k_next_s;

    function automatic logic [31:0] word_of(input logic [LINE_BYTES*8-1:0] data,
                                            input logic [WI_W-1:0]         idx,
                                            input logic                    err);
        if (err) begin
            word_of = 32'd0;
        end else begin
            word_of = data[{idx, 5'b00000} +: 32];
        end
    endfunction

    assign base0_s      = addr_r & ~ADDR_WIDTH'(LINE_BYTES - 1);
    assign base1_s      = base0_s + ADDR_WIDTH'(LINE_BYTES);
    assign want_base_s  = (state_r == WAIT_L1) ? base1_s : base0_s;
    assign line_fire_s  = bus.line_valid & line_ready_r;
    assign line_hit_s   = line_fire_s & ((state_r == WAIT_L0) | (state_r == WAIT_L1))
                          & (bus.line_addr == want_base_s);
    assign out_fire_s   = out_valid_r & bus.out_ready;
    // Line 0 ends either at the packet's last word or at the line boundary (crossing case).
    assign line_end_s   = out_last_r | (widx_r == WI_W'(LW - 1));
    assign first_widx_s = (state_r == WAIT_L1) ? WI_W'(0) : addr_r[LB-1:2];
    assign next_widx_s  = widx_r + WI_W'(1);
    assign k_load_s     = (state_r == WAIT_L0) ? K_W'(0) : k_r;
    assign k_next_s     = k_r + K_W'(1);

    // Packet sequencer: request latch, line capture and word emission.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            addr_r       <= '0;
            line_buf_r   <= '0;
            line_err_r   <= 1'b0;
            widx_r       <= '0;
            k_r          <= '0;
            out_valid_r  <= 1'b0;
            out_data_r   <= 32'd0;
            out_last_r   <= 1'b0;
            out_err_r    <= 1'b0;
            stale_drop_r <= 1'b0;
            req_ready_r  <= 1'b1;
            line_ready_r <= 1'b1;
            busy_r       <= 1'b0;
        end else begin
            stale_drop_r <= 1'b0;
            if (flush) begin
                state_r      <= IDLE;
                out_valid_r  <= 1'b0;
                out_data_r   <= 32'd0;
                out_last_r   <= 1'b0;
                out_err_r    <= 1'b0;
                req_ready_r  <= 1'b1;
                line_ready_r <= 1'b1;
                busy_r       <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (line_fire_s) begin
                            stale_drop_r <= 1'b1;
                        end
                        if (bus.req_valid) begin
                            addr_r      <= bus.req_addr & ~ADDR_WIDTH'(3);
                            state_r     <= WAIT_L0;
                            req_ready_r <= 1'b0;
                            busy_r      <= 1'b1;
                        end
                    end
                    WAIT_L0, WAIT_L1: begin
                        if (line_hit_s) begin
                            line_buf_r   <= bus.line_data;
                            line_err_r   <= bus.line_err;
                            widx_r       <= first_widx_s;
                            k_r          <= k_load_s;
                            out_valid_r  <= 1'b1;
                            out_data_r   <= word_of(bus.line_data, first_widx_s, bus.line_err);
                            out_err_r    <= bus.line_err;
                            out_last_r   <= (k_load_s == K_W'(NW - 1));
                            line_ready_r <= 1'b0;
                            state_r      <= (state_r == WAIT_L0) ? DRAIN_0 : DRAIN_1;
                        end else if (line_fire_s) begin
                            stale_drop_r <= 1'b1;
                        end
                    end
                    DRAIN_0, DRAIN_1: begin
                        if (out_fire_s) begin
                            if (line_end_s) begin
                                out_valid_r  <= 1'b0;
                                out_last_r   <= 1'b0;
                                out_err_r    <= 1'b0;
                                line_ready_r <= 1'b1;
                                if (out_last_r) begin
                                    state_r     <= IDLE;
                                    req_ready_r <= 1'b1;
                                    busy_r      <= 1'b0;
                                end else begin
                                    state_r <= WAIT_L1;
                                    k_r     <= k_next_s;
                                end
                            end else begin
                                widx_r     <= next_widx_s;
                                k_r        <= k_next_s;
                                out_data_r <= word_of(line_buf_r, next_widx_s, line_err_r);
                                out_last_r <= (k_next_s == K_W'(NW - 1));
                            end
                        end
                    end
                    default: begin
                        state_r      <= IDLE;
                        out_valid_r  <= 1'b0;
                        out_last_r   <= 1'b0;
                        out_err_r    <= 1'b0;
                        req_ready_r  <= 1'b1;
                        line_ready_r <= 1'b1;
                        busy_r       <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.line_ready = line_ready_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_data   = out_data_r;
    assign bus.out_last   = out_last_r;
    assign bus.out_err    = out_err_r;
    assign stale_drop     = stale_drop_r;
    assign busy           = busy_r;
endmodule
